// File: rtl/spi_regfile_periph.sv
// SPI register-file peripheral: decodes R/W + address + data frames from an SPI
// controller, writes a NUM_REGS x DATA_W bank, or shifts a register back on cipo.
module spi_regfile_periph #(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int CPOL     = 0,
    parameter int CPHA     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         copi,
    input  logic                         cs_n,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic                         frame_err
);

    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST_ADDR = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL      = CNT_W'(FRAME_W);
    localparam logic SCLK_IDLE   = (CPOL != 0);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);

    logic sclk_s1, sclk_s2, sclk_prev;
    logic copi_s1, copi_s2;
    logic cs_s1, cs_s2, cs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1   <= SCLK_IDLE;
            sclk_s2   <= SCLK_IDLE;
            sclk_prev <= SCLK_IDLE;
            copi_s1   <= 1'b0;
            copi_s2   <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            copi_s1   <= copi;
            copi_s2   <= copi_s1;
            cs_s1     <= cs_n;
            cs_s2     <= cs_s1;
            cs_prev   <= cs_s2;
        end
    end

    logic sample_edge, cs_fall, cs_rise, bit_edge;
    assign sample_edge = SAMPLE_RISE ? (sclk_s2 & ~sclk_prev) : (~sclk_s2 & sclk_prev);
    assign cs_fall     = cs_prev & ~cs_s2;
    assign cs_rise     = ~cs_prev & cs_s2;
    // A select falling edge outranks a coincident sample edge.
    assign bit_edge    = sample_edge & ~cs_s2 & ~cs_fall;

    logic [CNT_W-1:0]   count;
    logic [FRAME_W-2:0] rx_sr;
    logic [DATA_W-1:0]  tx_sr;
    logic               read_active;
    logic               over_seen;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    // Views of the frame as it would look with the bit now being sampled appended.
    logic [FRAME_W-1:0] full_word;
    logic [ADDR_W:0]    head_word;
    logic [ADDR_W-1:0]  wr_sel, rd_sel;
    logic [DATA_W-1:0]  wr_data, rd_data;
    logic               wr_rw, rd_rw, wr_hit;

    assign full_word = {rx_sr, copi_s2};
    assign head_word = {rx_sr[ADDR_W-1:0], copi_s2};
    assign wr_rw     = full_word[FRAME_W-1];
    assign wr_sel    = full_word[FRAME_W-2 -: ADDR_W];
    assign wr_data   = full_word[DATA_W-1:0];
    assign rd_rw     = head_word[ADDR_W];
    assign rd_sel    = head_word[ADDR_W-1:0];

    always_comb begin
        wr_hit  = 1'b0;
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel == ADDR_W'(i)) wr_hit = 1'b1;
            if (rd_sel == ADDR_W'(i)) rd_data = regs[i];
        end
    end

    logic commit, rd_load, tx_shift, overlong, abort;
    assign commit   = bit_edge && (count == CNT_LAST) && wr_rw && wr_hit;
    assign rd_load  = bit_edge && (count == CNT_LAST_ADDR) && !rd_rw;
    assign tx_shift = bit_edge && read_active && (count > CNT_LAST_ADDR) && (count < CNT_FULL);
    assign overlong = bit_edge && (count == CNT_FULL) && !over_seen;
    assign abort    = cs_rise && (count != '0) && (count < CNT_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            read_active <= 1'b0;
            over_seen   <= 1'b0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            frame_err   <= 1'b0;
        end else begin
            wr_strobe <= commit;
            frame_err <= overlong | abort;
            if (commit) wr_addr <= wr_sel;
            if (cs_fall) begin
                count       <= '0;
                rx_sr       <= '0;
                tx_sr       <= '0;
                read_active <= 1'b0;
                over_seen   <= 1'b0;
            end else if (bit_edge) begin
                if (count < CNT_FULL) begin
                    count <= count + 1'b1;
                    rx_sr <= {rx_sr[FRAME_W-3:0], copi_s2};
                end else begin
                    over_seen <= 1'b1;
                end
                // rd_data is already zero for addresses outside the bank.
                if (rd_load) begin
                    tx_sr       <= rd_data;
                    read_active <= 1'b1;
                end else if (tx_shift) begin
                    tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_sel == ADDR_W'(i)) regs[i] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
    end

    assign cipo_oe = read_active & ~cs_s2;
    assign cipo    = cipo_oe & tx_sr[DATA_W-1];

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: four instances, one per SPI mode, share one
// controller; a reference register model feeds expected queues read by monitors.
`timescale 1ns/1ps
module tb_spi_regfile_periph;

    localparam int NR = 5;
    localparam int DW = 8;
    localparam int AW = 7;
    localparam int FW = 1 + AW + DW;
    localparam int RW = NR * DW;
    localparam int Q  = 4;   // clk cycles per quarter SPI bit

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic copi = 1'b0;
    logic cs_n = 1'b1;
    logic sck_act = 1'b0;

    always #5 clk = ~clk;

    wire [3:0]    cipo, cipo_oe, wr_strobe, frame_err;
    wire [AW-1:0] wr_addr [4];
    wire [RW-1:0] regs_flat [4];

    int checks = 0;
    int errors = 0;

    logic [AW+RW-1:0] exp_wr_q[$];
    logic [DW-1:0]    exp_rd_q[$];
    int               exp_err_q[$];
    int wr_idx [4];
    int rd_idx [4];
    int err_idx [4];
    logic [DW-1:0] model [NR];

    task automatic check(input string name, input int m, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s mode %0d got %0h expected %0h", name, m, got, exp);
        end
    endtask

    task automatic missing(input string name, input int m);
        checks++;
        errors++;
        $display("FAIL %s mode %0d got event expected none", name, m);
    endtask

    function automatic logic [RW-1:0] model_flat();
        logic [RW-1:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam int   MCPOL = m / 2;
        localparam int   MCPHA = m % 2;
        localparam logic SAMPLE_LVL = (MCPOL == MCPHA);
        wire sclk_m = (MCPOL != 0) ? ~sck_act : sck_act;

        spi_regfile_periph #(
            .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .CPOL(MCPOL), .CPHA(MCPHA)
        ) dut (
            .clk(clk), .rst_n(rst_n), .sclk(sclk_m), .copi(copi), .cs_n(cs_n),
            .cipo(cipo[m]), .cipo_oe(cipo_oe[m]), .regs_flat(regs_flat[m]),
            .wr_strobe(wr_strobe[m]), .wr_addr(wr_addr[m]), .frame_err(frame_err[m])
        );

        initial begin : wr_mon
            logic prev;
            logic [AW+RW-1:0] e;
            prev = 1'b0;
            forever begin
                @(negedge clk);
                if (wr_strobe[m]) begin
                    check("strobe_width", m, prev, 1'b0);
                    if (wr_idx[m] >= exp_wr_q.size()) begin
                        missing("unexpected_strobe", m);
                    end else begin
                        e = exp_wr_q[wr_idx[m]];
                        wr_idx[m]++;
                        check("wr_addr", m, wr_addr[m], e[AW+RW-1:RW]);
                        check("wr_regs", m, regs_flat[m], e[RW-1:0]);
                    end
                end
                prev = wr_strobe[m];
            end
        end

        initial begin : err_mon
            logic prev;
            prev = 1'b0;
            forever begin
                @(negedge clk);
                if (frame_err[m]) begin
                    check("err_width", m, prev, 1'b0);
                    if (err_idx[m] >= exp_err_q.size()) missing("unexpected_frame_err", m);
                    else begin
                        checks++;
                        err_idx[m]++;
                    end
                end
                prev = frame_err[m];
            end
        end

        // Passive bus decoder acting as the controller's receive side.
        initial begin : bus_mon
            int bitn;
            logic rw;
            logic exp_oe;
            logic [DW-1:0] cap;
            forever begin
                @(negedge cs_n);
                bitn = 0;
                rw = 1'b0;
                cap = '0;
                while (cs_n == 1'b0) begin
                    @(sclk_m or cs_n);
                    if (cs_n == 1'b0 && sclk_m == SAMPLE_LVL && bitn < FW) begin
                        if (bitn == 0) rw = copi;
                        exp_oe = (bitn > AW) && !rw;
                        check("cipo_oe", m, cipo_oe[m], exp_oe);
                        if (exp_oe) cap = {cap[DW-2:0], cipo[m]};
                        bitn++;
                    end
                end
                if (bitn == FW && !rw) begin
                    if (rd_idx[m] >= exp_rd_q.size()) missing("unexpected_read", m);
                    else begin
                        check("read_data", m, cap, exp_rd_q[rd_idx[m]]);
                        rd_idx[m]++;
                    end
                end
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [FW-1:0] word, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            copi = (k < FW) ? word[FW-1-k] : 1'($urandom_range(0, 1));
            clk_wait(Q);
            sck_act = 1'b1;
            clk_wait(2 * Q);
            sck_act = 1'b0;
            clk_wait(Q);
        end
    endtask

    task automatic send_frame(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data, input int nbits);
        int a;
        a = int'(addr);
        if (nbits >= FW) begin
            if (rw && a < NR) begin
                model[a] = data;
                exp_wr_q.push_back({addr, model_flat()});
            end else if (!rw) begin
                exp_rd_q.push_back((a < NR) ? model[a] : 8'h00);
            end
        end
        if (nbits > FW || (nbits > 0 && nbits < FW)) exp_err_q.push_back(nbits);
        cs_n = 1'b0;
        clk_wait(4);
        shift_bits({rw, addr, data}, nbits);
        clk_wait(4);
        cs_n = 1'b1;
        clk_wait(12);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        for (int i = 0; i < NR; i++) model[i] = '0;
        clk_wait(5);
        rst_n = 1'b1;
        clk_wait(5);
        for (int m = 0; m < 4; m++) begin
            check("rst_regs", m, regs_flat[m], '0);
            check("rst_wr_addr", m, wr_addr[m], '0);
            check("rst_cipo", m, cipo[m], 1'b0);
            check("rst_cipo_oe", m, cipo_oe[m], 1'b0);
            check("rst_strobe", m, wr_strobe[m], 1'b0);
            check("rst_frame_err", m, frame_err[m], 1'b0);
        end

        send_frame(1'b1, 7'd2, 8'hA5, FW);
        for (int m = 0; m < 4; m++) begin
            check("reg2_a5", m, regs_flat[m], 40'h00_00_A5_00_00);
            check("wr_addr_2", m, wr_addr[m], 7'd2);
        end

        send_frame(1'b1, 7'd4, 8'h3C, FW);
        send_frame(1'b0, 7'd4, 8'($urandom), FW);
        send_frame(1'b1, 7'h10, 8'hFF, FW);
        send_frame(1'b0, 7'h10, 8'($urandom), FW);
        send_frame(1'b1, 7'd1, 8'h99, 10);
        send_frame(1'b1, 7'd1, 8'h66, FW);
        send_frame(1'b1, 7'd0, 8'h5A, FW + 1);
        send_frame(1'b0, 7'd0, 8'h00, 0);
        send_frame(1'b0, 7'd0, 8'($urandom), FW);

        for (int n = 0; n < 28; n++) begin
            logic rw;
            logic [AW-1:0] a;
            int sel, nb;
            rw = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, NR + 1));
            sel = $urandom_range(0, 9);
            nb = (sel == 0) ? 0 :
                 (sel == 1) ? $urandom_range(1, FW - 1) :
                 (sel == 2) ? $urandom_range(FW + 1, FW + 3) : FW;
            send_frame(rw, a, 8'($urandom), nb);
        end

        // Reset in the data phase of a read that is driving ones.
        send_frame(1'b1, 7'd3, 8'hFF, FW);
        cs_n = 1'b0;
        clk_wait(4);
        shift_bits({1'b0, 7'd3, 8'h00}, 12);
        clk_wait(4);
        for (int m = 0; m < 4; m++) check("cipo_before_reset", m, cipo[m], 1'b1);
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 4; m++) begin
            check("reset_cipo", m, cipo[m], 1'b0);
            check("reset_cipo_oe", m, cipo_oe[m], 1'b0);
            check("reset_regs", m, regs_flat[m], '0);
            check("reset_wr_addr", m, wr_addr[m], '0);
        end
        for (int i = 0; i < NR; i++) model[i] = '0;
        clk_wait(2);
        cs_n = 1'b1;
        clk_wait(4);
        rst_n = 1'b1;
        clk_wait(8);
        send_frame(1'b1, 7'd2, 8'h11, FW);
        send_frame(1'b0, 7'd2, 8'($urandom), FW);
        send_frame(1'b0, 7'd3, 8'($urandom), FW);

        clk_wait(20);
        for (int m = 0; m < 4; m++) begin
            check("write_count", m, wr_idx[m], exp_wr_q.size());
            check("read_count", m, rd_idx[m], exp_rd_q.size());
            check("err_count", m, err_idx[m], exp_err_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
